// File: rtl/pixel_job_scheduler_if.sv
// Bundle of the scheduler's engine-side job/result handshakes and its
// AXI4-Stream video output.
//   master : the scheduler. It drives job requests, result acks and the
//            video stream.
//   slave  : the environment (engines plus the VDMA sink).
// Signals:
//   eng_req_valid/x/y, eng_req_ready : one-hot job issue with a shared coordinate.
//   eng_res_valid/data, eng_res_ready: per-engine 24-bit RGB results.
//   out_stream_t*                    : 32-bit video beats, tuser=SOF, tlast=EOL.
interface pixel_job_scheduler_if #(
  parameter int NUM_ENG = 4,
  parameter int CW      = 10
);
  logic [NUM_ENG-1:0]    eng_req_valid;
  logic [CW-1:0]         eng_req_x;
  logic [CW-1:0]         eng_req_y;
  logic [NUM_ENG-1:0]    eng_req_ready;
  logic [NUM_ENG-1:0]    eng_res_valid;
  logic [NUM_ENG*24-1:0] eng_res_data;
  logic [NUM_ENG-1:0]    eng_res_ready;
  logic [31:0]           out_stream_tdata;
  logic [3:0]            out_stream_tkeep;
  logic                  out_stream_tvalid;
  logic                  out_stream_tready;
  logic                  out_stream_tuser;
  logic                  out_stream_tlast;

  modport master (
    output eng_req_valid, eng_req_x, eng_req_y, eng_res_ready,
    output out_stream_tdata, out_stream_tkeep, out_stream_tvalid,
    output out_stream_tuser, out_stream_tlast,
    input  eng_req_ready, eng_res_valid, eng_res_data, out_stream_tready
  );

  modport slave (
    input  eng_req_valid, eng_req_x, eng_req_y, eng_res_ready,
    input  out_stream_tdata, out_stream_tkeep, out_stream_tvalid,
    input  out_stream_tuser, out_stream_tlast,
    output eng_req_ready, eng_res_valid, eng_res_data, out_stream_tready
  );
endinterface

// File: rtl/pixel_job_scheduler.sv
// Frame sequencer for the fractal pixel datapath. It walks (x,y) over an
// X_SIZE x Y_SIZE frame and hands one coordinate job per cycle, round-robin,
// to NUM_ENG iteration engines. Results are retired in strict issue order onto
// an AXI4-Stream video output.
// Ports:
//   out_stream_aclk : sole clock
//   periph_resetn   : async active-low reset, shared with the engines
//   start           : 1-cycle pulse that begins a frame; ignored unless idle
//   continuous      : level; restart automatically after each frame
//   busy            : high while a frame is in progress (RUN/DRAIN/DONE)
//   frame_done      : 1-cycle pulse at the end of a frame
//   bus             : engine handshakes and the video stream (master side)
module pixel_job_scheduler #(
  parameter int X_SIZE  = 640,
  parameter int Y_SIZE  = 480,
  parameter int NUM_ENG = 4,
  parameter int CW      = 10
) (
  input  logic                   out_stream_aclk,
  input  logic                   periph_resetn,
  input  logic                   start,
  input  logic                   continuous,
  output logic                   busy,
  output logic                   frame_done,
  pixel_job_scheduler_if.master  bus
);

  localparam int PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  // Per-engine vectors are widened to 2**PW so that a pointer index always
  // fits exactly. The extra lanes are never set.
  localparam int NP = 2 ** PW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     iss_x, iss_y, out_x, out_y;
  logic [PW-1:0]     iss_ptr, ret_ptr;
  logic [NP-1:0]     eng_busy, busy_n;

  logic [NP-1:0]     req_ready_pad, res_valid_pad, req_valid_pad, res_ready_pad;
  logic [NP*24-1:0]  res_data_pad;
  logic              issue_ok, iss_fire, ret_fire, tvalid;
  logic              last_job, last_pix, start_frame;

  assign req_ready_pad = NP'(bus.eng_req_ready);
  assign res_valid_pad = NP'(bus.eng_res_valid);
  assign res_data_pad  = (NP*24)'(bus.eng_res_data);

  // Issue side: a job is offered to the engine at iss_ptr only once that
  // engine has no job outstanding.
  assign issue_ok      = (state == RUN) && !eng_busy[iss_ptr];
  assign iss_fire      = issue_ok && req_ready_pad[iss_ptr];
  assign req_valid_pad = issue_ok ? (NP'(1) << iss_ptr) : '0;
  assign last_job      = (iss_x == CW'(X_SIZE - 1)) && (iss_y == CW'(Y_SIZE - 1));

  // Retire side: only the engine at ret_ptr may present a result. A valid
  // result from any other engine waits, which keeps the output in order.
  assign tvalid        = ((state == RUN) || (state == DRAIN)) &&
                         eng_busy[ret_ptr] && res_valid_pad[ret_ptr];
  assign ret_fire      = tvalid && bus.out_stream_tready;
  assign res_ready_pad = ret_fire ? (NP'(1) << ret_ptr) : '0;
  assign last_pix      = (out_x == CW'(X_SIZE - 1)) && (out_y == CW'(Y_SIZE - 1));

  assign start_frame   = ((state == IDLE) && start) || ((state == DONE) && continuous);

  assign bus.eng_req_valid     = req_valid_pad[NUM_ENG-1:0];
  assign bus.eng_req_x         = iss_x;
  assign bus.eng_req_y         = iss_y;
  assign bus.eng_res_ready     = res_ready_pad[NUM_ENG-1:0];
  // The engine holds its data until acked and ret_ptr does not move during a
  // stall, so the beat stays stable while tready is low.
  assign bus.out_stream_tdata  = tvalid ? {8'h00, res_data_pad[24*ret_ptr +: 24]} : '0;
  assign bus.out_stream_tkeep  = 4'hF;
  assign bus.out_stream_tvalid = tvalid;
  assign bus.out_stream_tuser  = tvalid && (out_x == '0) && (out_y == '0);
  assign bus.out_stream_tlast  = tvalid && (out_x == CW'(X_SIZE - 1));

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave it unassigned and infer a latch.
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (iss_fire && last_job) state_n = DRAIN;
      DRAIN:   if (ret_fire && last_pix) state_n = DONE;
      DONE:    state_n = continuous ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The retire clear is applied first and the issue set second. The two
  // always hit different engines, because issue needs !busy and retire
  // needs busy.
  always_comb begin
    busy_n = eng_busy;
    if (ret_fire) busy_n[ret_ptr] = 1'b0;
    if (iss_fire) busy_n[iss_ptr] = 1'b1;
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    // NOTE: registers use non-blocking assignments so all of them update from the same pre-edge values.
    if (!periph_resetn) state <= IDLE;
    else                state <= state_n;
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      iss_x    <= '0;
      iss_y    <= '0;
      out_x    <= '0;
      out_y    <= '0;
      iss_ptr  <= '0;
      ret_ptr  <= '0;
      eng_busy <= '0;
    end else if (start_frame) begin
      iss_x    <= '0;
      iss_y    <= '0;
      out_x    <= '0;
      out_y    <= '0;
      iss_ptr  <= '0;
      ret_ptr  <= '0;
      eng_busy <= '0;
    end else begin
      eng_busy <= busy_n;
      if (iss_fire) begin
        iss_ptr <= (iss_ptr == PW'(NUM_ENG - 1)) ? '0 : iss_ptr + PW'(1);
        if (iss_x == CW'(X_SIZE - 1)) begin
          iss_x <= '0;
          iss_y <= (iss_y == CW'(Y_SIZE - 1)) ? '0 : iss_y + CW'(1);
        end else begin
          iss_x <= iss_x + CW'(1);
        end
      end
      if (ret_fire) begin
        ret_ptr <= (ret_ptr == PW'(NUM_ENG - 1)) ? '0 : ret_ptr + PW'(1);
        if (out_x == CW'(X_SIZE - 1)) begin
          out_x <= '0;
          out_y <= (out_y == CW'(Y_SIZE - 1)) ? '0 : out_y + CW'(1);
        end else begin
          out_x <= out_x + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_job_scheduler.sv
// Directed bench for pixel_job_scheduler on a 4x2 frame. DUT a has two
// engines. DUT b has a single engine and is used for the repeated-start case.
module tb_pixel_job_scheduler;

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, cont_a = 1'b0, busy_a, done_pulse_a;
  logic        start_b = 1'b0, busy_b, done_pulse_b;
  logic [31:0] cyc = '0;
  logic        tready_mode = 1'b0;
  logic [3:0]  tready_pat = 4'b1001;  // cycle phases 0..3 -> 1,0,0,1

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  pixel_job_scheduler_if #(.NUM_ENG(2), .CW(3)) bus_a ();
  pixel_job_scheduler_if #(.NUM_ENG(1), .CW(3)) bus_b ();

  pixel_job_scheduler #(.X_SIZE(4), .Y_SIZE(2), .NUM_ENG(2), .CW(3)) dut_a (
    .out_stream_aclk(clk), .periph_resetn(rst_n), .start(start_a),
    .continuous(cont_a), .busy(busy_a), .frame_done(done_pulse_a), .bus(bus_a)
  );

  pixel_job_scheduler #(.X_SIZE(4), .Y_SIZE(2), .NUM_ENG(1), .CW(3)) dut_b (
    .out_stream_aclk(clk), .periph_resetn(rst_n), .start(start_b),
    .continuous(1'b0), .busy(busy_b), .frame_done(done_pulse_b), .bus(bus_b)
  );

  // Engine models. Each accepts a job, then raises a result RGB = x + 16*y
  // after dly cycles and holds it until acked.
  int          dly_a [2];
  int          cnt_a [2];
  logic        pend_a [2];
  logic        rv_a [2];
  logic [23:0] dat_a [2];
  logic        pend_b, rv_b;
  int          cnt_b;
  logic [23:0] dat_b;

  assign bus_a.eng_req_ready     = 2'b11;
  assign bus_a.eng_res_valid     = {rv_a[1], rv_a[0]};
  assign bus_a.eng_res_data      = {dat_a[1], dat_a[0]};
  assign bus_a.out_stream_tready = tready_mode ? tready_pat[cyc[1:0]] : 1'b1;
  assign bus_b.eng_req_ready     = 1'b1;
  assign bus_b.eng_res_valid     = rv_b;
  assign bus_b.eng_res_data      = dat_b;
  assign bus_b.out_stream_tready = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        pend_a[i] <= 1'b0;
        rv_a[i]   <= 1'b0;
        cnt_a[i]  <= 0;
        dat_a[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rv_a[i] && bus_a.eng_res_ready[i[0]]) begin
          rv_a[i]   <= 1'b0;
          pend_a[i] <= 1'b0;
        end
        if (bus_a.eng_req_valid[i[0]]) begin
          pend_a[i] <= 1'b1;
          cnt_a[i]  <= dly_a[i];
          dat_a[i]  <= 24'(int'(bus_a.eng_req_x) + 16 * int'(bus_a.eng_req_y));
        end else if (pend_a[i] && !rv_a[i]) begin
          if (cnt_a[i] <= 1) rv_a[i] <= 1'b1;
          else               cnt_a[i] <= cnt_a[i] - 1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_b <= 1'b0;
      rv_b   <= 1'b0;
      cnt_b  <= 0;
      dat_b  <= '0;
    end else begin
      if (rv_b && bus_b.eng_res_ready[0]) begin
        rv_b   <= 1'b0;
        pend_b <= 1'b0;
      end
      if (bus_b.eng_req_valid[0]) begin
        pend_b <= 1'b1;
        cnt_b  <= 1;
        dat_b  <= 24'(int'(bus_b.eng_req_x) + 16 * int'(bus_b.eng_req_y));
      end else if (pend_b && !rv_b) begin
        if (cnt_b <= 1) rv_b <= 1'b1;
        else            cnt_b <= cnt_b - 1;
      end
    end
  end

  // Output monitors sample on the falling edge. A beat is recorded when
  // tvalid and tready are both high there.
  beat_t cur_a, cur_b, prev_a;
  beat_t q_a[$];
  beat_t q_b[$];
  int    done_t[$];
  int    done_a = 0, done_b = 0, stall_err = 0, stall_seen = 0;
  logic  prev_stall = 1'b0;

  assign cur_a = {bus_a.out_stream_tdata, bus_a.out_stream_tuser, bus_a.out_stream_tlast};
  assign cur_b = {bus_b.out_stream_tdata, bus_b.out_stream_tuser, bus_b.out_stream_tlast};

  always @(negedge clk) begin
    if (bus_a.out_stream_tvalid && bus_a.out_stream_tready) q_a.push_back(cur_a);
    if (bus_b.out_stream_tvalid && bus_b.out_stream_tready) q_b.push_back(cur_b);
    if (rst_n && prev_stall) begin
      stall_seen <= stall_seen + 1;
      if (!bus_a.out_stream_tvalid || cur_a != prev_a) stall_err <= stall_err + 1;
    end
    prev_stall <= rst_n && bus_a.out_stream_tvalid && !bus_a.out_stream_tready;
    prev_a     <= cur_a;
    if (done_pulse_a) begin
      done_a <= done_a + 1;
      done_t.push_back(int'(cyc));
    end
    if (done_pulse_b) done_b <= done_b + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected beat i of a stream of back-to-back 4x2 frames.
  function automatic beat_t exp_beat(input int i);
    beat_t r;
    int x, y;
    x   = i % 4;
    y   = (i / 4) % 2;
    r.d = 32'(x + 16 * y);
    r.u = (x == 0) && (y == 0);
    r.l = (x == 3);
    return r;
  endfunction

  task automatic check_beats(input string tag, input beat_t q[$], input int n);
    check({tag, "_count"}, 64'(q.size()), 64'(n));
    for (int i = 0; i < q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 64'(q[i]), 64'(exp_beat(i)));
  endtask

  task automatic wait_done_a(input int n);
    int b = 0;
    while (done_a < n && b < 400) begin
      cycles(1);
      b++;
    end
    check("wait_frame_done_a", 64'(done_a >= n), 64'(1));
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    cycles(1);
    start_a = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   64'(busy_a), 64'(0));
    check({tag, "_done"},   64'(done_pulse_a), 64'(0));
    check({tag, "_reqv"},   64'(bus_a.eng_req_valid), 64'(0));
    check({tag, "_reqxy"},  64'({bus_a.eng_req_x, bus_a.eng_req_y}), 64'(0));
    check({tag, "_resr"},   64'(bus_a.eng_res_ready), 64'(0));
    check({tag, "_tvalid"}, 64'(bus_a.out_stream_tvalid), 64'(0));
    check({tag, "_tdata"},  64'(bus_a.out_stream_tdata), 64'(0));
    check({tag, "_tuser"},  64'(bus_a.out_stream_tuser), 64'(0));
    check({tag, "_tlast"},  64'(bus_a.out_stream_tlast), 64'(0));
    check({tag, "_tkeep"},  64'(bus_a.out_stream_tkeep), 64'(4'hF));
  endtask

  initial begin
    int base, b;
    dly_a[0] = 1;
    dly_a[1] = 1;

    // Reset state
    cycles(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cycles(2);
    check("idle_busy", 64'(busy_a), 64'(0));

    // 1: single frame with unit engine latency
    q_a.delete();
    pulse_a();
    check("t1_busy_after_start", 64'(busy_a), 64'(1));
    wait_done_a(1);
    cycles(5);
    check_beats("t1", q_a, 8);
    check("t1_done_count", 64'(done_a), 64'(1));
    check("t1_busy_end", 64'(busy_a), 64'(0));

    // 2: engine 1 answers 5 cycles ahead of engine 0
    dly_a[0] = 7;
    q_a.delete();
    pulse_a();
    b = 0;
    while (!bus_a.eng_res_valid[1] && b < 50) begin
      cycles(1);
      b++;
    end
    check("t2_eng1_result_seen", 64'(bus_a.eng_res_valid[1]), 64'(1));
    check("t2_eng1_held", 64'(bus_a.eng_res_ready[1]), 64'(0));
    check("t2_no_early_beat", 64'(bus_a.out_stream_tvalid), 64'(0));
    check("t2_nothing_retired", 64'(q_a.size()), 64'(0));
    wait_done_a(2);
    cycles(5);
    check_beats("t2", q_a, 8);
    dly_a[0] = 1;

    // 3: tready 1,0,0,1 pattern
    tready_mode = 1'b1;
    q_a.delete();
    pulse_a();
    wait_done_a(3);
    cycles(5);
    tready_mode = 1'b0;
    check_beats("t3", q_a, 8);
    check("t3_stall_stable", 64'(stall_err), 64'(0));
    check("t3_stalls_seen", 64'(stall_seen > 0), 64'(1));

    // 4: continuous mode, two frames from one start
    q_a.delete();
    base = done_a;
    cont_a = 1'b1;
    pulse_a();
    wait_done_a(base + 1);
    cont_a = 1'b0;
    wait_done_a(base + 2);
    cycles(5);
    check_beats("t4", q_a, 16);
    check("t4_done_count", 64'(done_a - base), 64'(2));
    if (done_t.size() >= base + 2)
      check("t4_done_spacing", 64'(done_t[base + 1] - done_t[base] >= 9), 64'(1));
    else
      check("t4_done_spacing_present", 64'(done_t.size()), 64'(base + 2));
    check("t4_busy_end", 64'(busy_a), 64'(0));

    // 5: reset mid-frame, then restart
    q_a.delete();
    pulse_a();
    b = 0;
    while (q_a.size() < 3 && b < 50) begin
      cycles(1);
      b++;
    end
    check("t5_three_beats", 64'(q_a.size() >= 3), 64'(1));
    base = done_a;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_in_reset");
    cycles(2);
    check_reset_outputs("t5_held_reset");
    rst_n = 1'b1;
    cycles(1);
    q_a.delete();
    pulse_a();
    wait_done_a(base + 1);
    cycles(5);
    check_beats("t5", q_a, 8);
    check("t5_done_count", 64'(done_a - base), 64'(1));

    // 6: single engine, extra start pulse during RUN
    q_b.delete();
    start_b = 1'b1;
    cycles(1);
    start_b = 1'b0;
    cycles(3);
    check("t6_busy_run", 64'(busy_b), 64'(1));
    start_b = 1'b1;
    cycles(1);
    start_b = 1'b0;
    b = 0;
    while (done_b < 1 && b < 400) begin
      cycles(1);
      b++;
    end
    check("t6_wait_done", 64'(done_b >= 1), 64'(1));
    cycles(20);
    check_beats("t6", q_b, 8);
    check("t6_done_count", 64'(done_b), 64'(1));
    check("t6_busy_end", 64'(busy_b), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
